sfx_sequencer: RTL
==================

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: system clock frequency.
REQ-002 SHALL have parameter BEAT_HZ, default 8: beat rate; one beat = 1/BEAT_HZ s.
REQ-003 SHALL have parameter N_EVT, default 4, range 1..8: number of sound-event channels.
REQ-004 SHALL have parameter SEQ_LEN, default 8, range 2..16: beats per effect sequence.
REQ-005 SHALL have parameter DUTY_W, default 10: duty-code width; 50 % = 2^(DUTY_W-1).
REQ-006 SHALL have port clk, input, 1: sole clock.
REQ-007 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port evt, input, N_EVT: level event requests (collisions, score); index 0 = highest priority.
REQ-009 SHALL have port bg_en, input, 1: loop background melody when no effect plays.
REQ-010 SHALL have port mute, input, 1: force audio_out low; sequencing continues.
REQ-011 SHALL have port audio_out, output, 1: square-wave tone to the speaker amplifier.
REQ-012 SHALL have port gain_n, output, 1: constant 1 (no extra gain).
REQ-013 SHALL have port amp_on, output, 1: 1 after reset release, 0 during reset.
REQ-014 SHALL have port busy, output, 1: 1 while an effect sequence plays.
REQ-015 SHALL have port cur_evt, output, 3: index of playing effect; 0 when not busy.

Function
REQ-016 SHALL assert an internal one-cycle beat tick every CLK_HZ/BEAT_HZ cycles (integer division), first tick CLK_HZ/BEAT_HZ cycles after reset release.
REQ-017 SHALL detect rising edges of each evt bit (registered previous value) and set that bit in a pending register; re-edges on an already pending bit are absorbed.
REQ-018 SHALL implement states IDLE, BG, PLAY.
REQ-019 IDLE: on tick, go PLAY if any pending, else BG if bg_en, else stay; note = rest.
REQ-020 PLAY start: select lowest-index pending bit, clear it, step = 0, cur_evt = index, busy = 1, effective on the tick.
REQ-021 PLAY: step advances on each tick; after step SEQ_LEN-1 completes, go PLAY (next pending), BG (bg_en) or IDLE, on that same tick.
REQ-022 Preemption: a pending index strictly lower than cur_evt SHALL restart PLAY with it at the next tick; the preempted effect is dropped, not re-queued.
REQ-023 BG: background step counter wraps at SEQ_LEN; any pending bit moves to PLAY at next tick; bg_en low moves to IDLE at next tick; BG step resumes where it stopped.
REQ-024 Note code (6 bits, 0 = rest) SHALL come from combinational lookup (effect/background, step); half-period count from a second lookup, both in package.
REQ-025 Tone generator: half-period counter toggles audio_out at terminal count; note change resets counter and drives audio_out low in the same cycle; rest holds audio_out low.
REQ-026 mute SHALL gate audio_out to 0 combinationally-free (registered output, one-cycle latency).
REQ-027 Simultaneous evt edge and tick: edge is latched and considered at the following tick, not the current one.

Reset
REQ-028 While reset = 0 at a clk edge: state IDLE, pending 0, steps 0, counters 0, audio_out 0, busy 0, cur_evt 0, amp_on 0; gain_n 1 always.
REQ-029 Reset asserted mid-PLAY SHALL abandon the effect with no residual tone on the next edge.

Structure
REQ-030 Package sfx_pkg SHALL hold the state enum, note-code type, note-to-half-period function (parameterised by CLK_HZ), effect and background sequence tables.
REQ-031 Tone generator SHALL be sub-module sfx_tone_gen (clk, reset, half_period, mute, out).

Verification (CLK_HZ=1000, BEAT_HZ=10, N_EVT=4, SEQ_LEN=4)
REQ-032 Reset release, no events, bg_en=0 -> audio_out 0, busy 0 for 1000 cycles; amp_on 1 from first cycle after release.
REQ-033 evt[2] pulse at cycle 10 -> busy=1, cur_evt=2 from cycle 100; busy=0 at cycle 500.
REQ-034 evt[3] then evt[1] within one beat -> evt[1] plays first, evt[3] follows immediately at its end.
REQ-035 evt[3] playing, evt[0] edge at step 1 -> cur_evt=0 at next tick; evt[3] never resumes.
REQ-036 bg_en=1, evt[1] during BG step 2 -> PLAY, then BG resumes at step 2; audio_out half-period matches table.
REQ-037 reset low during PLAY -> next edge audio_out 0, busy 0, pending 0; mute=1 -> audio_out 0 one cycle later, busy unchanged.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types, note tables and note-to-pitch helper for the sound-effect sequencer.
package sfx_pkg;

   typedef enum logic [1:0] {StIdle, StBg, StPlay} state_t;

   typedef logic [5:0] note_t;

   localparam note_t       NOTE_REST    = 6'd0;
   // Note code n sounds at n * NOTE_STEP_HZ (harmonic series on a 16 Hz base).
   localparam int unsigned NOTE_STEP_HZ = 16;
   localparam int unsigned MAX_EVT      = 8;
   localparam int unsigned MAX_STEPS    = 16;

   localparam int unsigned EFX_TBL [MAX_EVT][MAX_STEPS] = '{
      '{ 8,  6,  4,  2,  8,  6,  4,  2, 12, 10,  8,  6,  4,  3,  2,  1},
      '{ 2,  4,  6,  8, 10, 12, 16, 20,  2,  4,  6,  8, 10, 12, 16, 20},
      '{ 5,  5,  3,  3,  5,  5,  3,  3,  6,  6,  4,  4,  6,  6,  4,  4},
      '{ 1,  3,  1,  3,  2,  4,  2,  4,  1,  3,  1,  3,  2,  4,  2,  4},
      '{16, 14, 12, 10,  8,  6,  4,  2, 16, 14, 12, 10,  8,  6,  4,  2},
      '{ 3,  6,  9, 12, 15, 18, 21, 24, 27, 30, 33, 36, 39, 42, 45, 48},
      '{20,  0, 20,  0, 24,  0, 24,  0, 20,  0, 20,  0, 24,  0, 24,  0},
      '{32, 24, 16,  8, 32, 24, 16,  8, 32, 24, 16,  8, 32, 24, 16,  8}
   };

   localparam int unsigned BG_TBL [MAX_STEPS] = '{
      3, 4, 5, 6, 4, 3, 2, 3, 5, 6, 8, 6, 5, 4, 3, 2
   };

   function automatic note_t efx_note(logic [2:0] idx, logic [3:0] step);
      return note_t'(EFX_TBL[idx][step]);
   endfunction

   function automatic note_t bg_note(logic [3:0] step);
      return note_t'(BG_TBL[step]);
   endfunction

   // Clock cycles per half period of the note; 0 means rest.
   function automatic logic [31:0] note_half_period(note_t note, int unsigned clk_hz);
      int unsigned hp;
      hp = 0;
      if (note != NOTE_REST) begin
         hp = clk_hz / (2 * NOTE_STEP_HZ * 32'(note));
         if (hp == 0) begin
            hp = 1;
         end
      end
      return hp;
   endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave tone generator: toggles every half_period cycles, silent on rest or mute.
module sfx_tone_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] half_period,
   input  logic        mute,
   output logic        out
);

   logic [31:0] hp_q;
   logic [31:0] cnt_q, cnt_d;
   logic        tone_q, tone_d;

   always_comb begin
      cnt_d  = cnt_q + 32'd1;
      tone_d = tone_q;
      // A new pitch restarts the waveform from its low phase.
      if (half_period != hp_q || half_period == '0) begin
         cnt_d  = '0;
         tone_d = 1'b0;
      end else if (cnt_q >= half_period - 32'd1) begin
         cnt_d  = '0;
         tone_d = ~tone_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hp_q   <= '0;
         cnt_q  <= '0;
         tone_q <= 1'b0;
         out    <= 1'b0;
      end else begin
         hp_q   <= half_period;
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
         out    <= tone_d & ~mute;
      end
   end

endmodule

// File: rtl/sfx_sequencer.sv
// Beat-timed sound-effect sequencer: prioritised event effects over a looping background tune.
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned BEAT_HZ = 8,
   parameter int unsigned N_EVT   = 4,
   parameter int unsigned SEQ_LEN = 8,
   parameter int unsigned DUTY_W  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_EVT-1:0] evt,
   input  logic             bg_en,
   input  logic             mute,
   output logic             audio_out,
   output logic             gain_n,
   output logic             amp_on,
   output logic             busy,
   output logic [2:0]       cur_evt
);

   localparam int unsigned TICK_DIV  = CLK_HZ / BEAT_HZ;
   localparam logic [3:0]  LAST_STEP = 4'(SEQ_LEN - 1);

   if (N_EVT < 1 || N_EVT > MAX_EVT || SEQ_LEN < 2 || SEQ_LEN > MAX_STEPS ||
       DUTY_W < 2 || CLK_HZ < BEAT_HZ) begin : g_param_err
      $error("sfx_sequencer: parameter out of range");
   end

   state_t           state_q;
   logic [31:0]      tick_cnt_q;
   logic             tick;
   logic [N_EVT-1:0] evt_q, evt_rise, pending_q, clr_mask;
   logic [3:0]       step_q, bg_step_q;
   logic             pend_any, start_play;
   logic [2:0]       pend_idx;
   note_t            note;
   logic [31:0]      half_period;

   assign gain_n   = 1'b1;
   assign tick     = (tick_cnt_q == TICK_DIV - 1);
   assign evt_rise = evt & ~evt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt_q <= '0;
         evt_q      <= '0;
         amp_on     <= 1'b0;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 32'd1;
         evt_q      <= evt;
         amp_on     <= 1'b1;
      end
   end

   always_comb begin
      pend_any = |pending_q;
      pend_idx = '0;
      for (int i = int'(N_EVT) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            pend_idx = 3'(i);
         end
      end
      // In PLAY a new effect starts only by preemption or at the end of the current one.
      start_play = tick && pend_any &&
                   (state_q != StPlay || pend_idx < cur_evt || step_q == LAST_STEP);
      clr_mask   = start_play ? (N_EVT'(1) << pend_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         pending_q <= '0;
         step_q    <= '0;
         bg_step_q <= '0;
         busy      <= 1'b0;
         cur_evt   <= '0;
      end else begin
         // Edges arriving on a tick are only seen by the following tick.
         pending_q <= (pending_q & ~clr_mask) | evt_rise;
         if (start_play) begin
            state_q <= StPlay;
            step_q  <= '0;
            busy    <= 1'b1;
            cur_evt <= pend_idx;
         end else if (tick) begin
            unique case (state_q)
               StIdle: begin
                  if (bg_en) begin
                     state_q <= StBg;
                  end
               end
               StBg: begin
                  if (!bg_en) begin
                     state_q <= StIdle;
                  end else begin
                     bg_step_q <= (bg_step_q == LAST_STEP) ? '0 : bg_step_q + 4'd1;
                  end
               end
               StPlay: begin
                  if (step_q == LAST_STEP) begin
                     state_q <= bg_en ? StBg : StIdle;
                     busy    <= 1'b0;
                     cur_evt <= '0;
                  end else begin
                     step_q <= step_q + 4'd1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      unique case (state_q)
         StPlay:  note = efx_note(cur_evt, step_q);
         StBg:    note = bg_note(bg_step_q);
         default: note = NOTE_REST;
      endcase
   end

   assign half_period = note_half_period(note, CLK_HZ);

   sfx_tone_gen u_tone_gen (
      .clk         (clk),
      .reset       (reset),
      .half_period (half_period),
      .mute        (mute),
      .out         (audio_out)
   );

endmodule
